// File: rtl/seg7_digit_capture.sv
// seg7_digit_capture: sync + glitch-filter a 7-seg bus (clk, reset, seg_in) and report digit, digit_valid, step, seq_error, pattern_error, period, period_valid
module seg7_digit_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  output logic [3:0]          digit,
  output logic                digit_valid,
  output logic                step,
  output logic                seq_error,
  output logic                pattern_error,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);
  typedef enum logic {IDLE, TRACK} state_t;
  localparam logic [7:0] S_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] S_PRE = 8'(STABLE_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] P_MAX = '1;
  state_t state;
  logic [6:0] s1, s2, cand, acc;
  logic [7:0] cnt;
  logic [PERIOD_W-1:0] pcnt, pinc;
  logic stepped, accept, legal;
  logic [3:0] dec, nxt;
  always_comb begin
    legal = 1'b1;
    dec = 4'd0;
    case (cand)
      7'h3F: dec = 4'd0;
      7'h06: dec = 4'd1;
      7'h5B: dec = 4'd2;
      7'h4F: dec = 4'd3;
      7'h66: dec = 4'd4;
      7'h6D: dec = 4'd5;
      7'h7D: dec = 4'd6;
      7'h07: dec = 4'd7;
      7'h7F: dec = 4'd8;
      7'h6F: dec = 4'd9;
      default: legal = 1'b0;
    endcase
  end
  assign accept = s2 == cand && cnt == S_PRE && cand != acc;
  assign pinc = pcnt == P_MAX ? P_MAX : pcnt + 1'b1;
  assign nxt = digit == 4'd9 ? 4'd0 : digit + 4'd1;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      cand <= '0;
      acc <= '0;
      cnt <= '0;
      pcnt <= '0;
      stepped <= 1'b0;
      state <= IDLE;
      digit <= '0;
      digit_valid <= 1'b0;
      step <= 1'b0;
      seq_error <= 1'b0;
      pattern_error <= 1'b0;
      period <= '0;
      period_valid <= 1'b0;
    end else begin
      s1 <= seg_in;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt <= 8'd1;
      end else if (cnt != S_MAX) begin
        cnt <= cnt + 8'd1;
      end
      step <= accept;
      seq_error <= accept && legal && state == TRACK && dec != nxt;
      pattern_error <= accept && !legal && cand != 7'h00;
      if (accept) begin
        acc <= cand;
        digit_valid <= legal;
        if (legal) begin
          digit <= dec;
          state <= TRACK;
        end
        stepped <= 1'b1;
        if (stepped) begin
          period <= pinc;
          period_valid <= 1'b1;
        end
        pcnt <= '0;
      end else begin
        pcnt <= pinc;
      end
    end
  end
endmodule

// File: tb/tb_seg7_digit_capture.sv
// tb_seg7_digit_capture: vector table, corner sequences and random traffic against a window-based reference model
module tb_seg7_digit_capture;
  localparam int S = 4;
  localparam int PW = 10;
  localparam int PMAX = (1 << PW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] seg_in = 7'h00;
  logic [3:0] digit;
  logic digit_valid, step, seq_error, pattern_error, period_valid;
  logic [PW-1:0] period;
  int checks = 0;
  int errors = 0;
  seg7_digit_capture #(.STABLE_CYCLES(S), .PERIOD_W(PW)) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .digit(digit),
    .digit_valid(digit_valid),
    .step(step),
    .seq_error(seq_error),
    .pattern_error(pattern_error),
    .period(period),
    .period_valid(period_valid)
  );
  always #5 clk = ~clk;
  logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (lut[i] == p) return i;
    return -1;
  endfunction
  logic [6:0] hist [$];
  logic [6:0] m_acc;
  int m_digit, m_period, last_step, cyc;
  bit m_dv, m_step, m_seq, m_pat, m_pv, have_prev, started;
  initial begin
    cyc = 0;
    started = 0;
  end
  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      for (int i = 0; i < S + 2; i++) hist.push_back(7'h00);
      m_acc = 7'h00;
      m_digit = 0;
      m_dv = 0;
      m_step = 0;
      m_seq = 0;
      m_pat = 0;
      m_period = 0;
      m_pv = 0;
      have_prev = 0;
      last_step = -1;
      started = 1;
    end else begin
      logic [6:0] nv;
      bit same;
      int d;
      hist.push_back(seg_in);
      void'(hist.pop_front());
      same = 1;
      for (int i = 1; i < S; i++) if (hist[i] != hist[0]) same = 0;
      nv = same ? hist[0] : m_acc;
      m_step = nv != m_acc;
      m_seq = 0;
      m_pat = 0;
      if (m_step) begin
        d = decode(nv);
        if (d >= 0) begin
          m_seq = have_prev && d != (m_digit + 1) % 10;
          m_digit = d;
          have_prev = 1;
        end else begin
          m_pat = nv != 7'h00;
        end
        m_dv = d >= 0;
        if (last_step >= 0) begin
          m_period = (cyc - last_step) > PMAX ? PMAX : cyc - last_step;
          m_pv = 1;
        end
        last_step = cyc;
        m_acc = nv;
      end
    end
    cyc++;
  end
  int nprint = 0;
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (digit !== 4'(m_digit) || digit_valid !== m_dv || step !== m_step || seq_error !== m_seq ||
          pattern_error !== m_pat || period !== PW'(m_period) || period_valid !== m_pv) begin
        errors++;
        if (nprint < 20)
          $display("FAIL model t=%0t dig/dv/stp/sq/pt/per/pv got %0d %b %b %b %b %0d %b expected %0d %b %b %b %b %0d %b",
                   $time, digit, digit_valid, step, seq_error, pattern_error, period, period_valid,
                   m_digit, m_dv, m_step, m_seq, m_pat, m_period, m_pv);
        nprint++;
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  int nsteps;
  bit st_seq, st_pat;
  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (step) begin
        nsteps++;
        st_seq = seq_error;
        st_pat = pattern_error;
      end
    end
  endtask
  typedef struct {
    logic [6:0] seg;
    int n;
    int dg;
    bit dv;
    bit sq;
    bit pt;
    int per;
    bit pv;
  } vec_t;
  vec_t vecs [17];
  initial begin
    vecs[0]  = '{7'h3F, 1000, 0, 1, 0, 0, 0, 0};
    vecs[1]  = '{7'h06, 1000, 1, 1, 0, 0, 1000, 1};
    vecs[2]  = '{7'h5B, 1000, 2, 1, 0, 0, 1000, 1};
    vecs[3]  = '{7'h4F, 1000, 3, 1, 0, 0, 1000, 1};
    vecs[4]  = '{7'h66, 1000, 4, 1, 0, 0, 1000, 1};
    vecs[5]  = '{7'h6D, 1000, 5, 1, 0, 0, 1000, 1};
    vecs[6]  = '{7'h7D, 1000, 6, 1, 0, 0, 1000, 1};
    vecs[7]  = '{7'h07, 1000, 7, 1, 0, 0, 1000, 1};
    vecs[8]  = '{7'h7F, 1000, 8, 1, 0, 0, 1000, 1};
    vecs[9]  = '{7'h6F, 1000, 9, 1, 0, 0, 1000, 1};
    vecs[10] = '{7'h3F, 1000, 0, 1, 0, 0, 1000, 1};
    vecs[11] = '{7'h4F, 50, 3, 1, 1, 0, 1000, 1};
    vecs[12] = '{7'h6D, 50, 5, 1, 1, 0, 50, 1};
    vecs[13] = '{7'h49, 1100, 5, 0, 0, 1, 50, 1};
    vecs[14] = '{7'h00, 50, 5, 0, 0, 0, 1023, 1};
    vecs[15] = '{7'h6D, 50, 5, 1, 1, 0, 50, 1};
    vecs[16] = '{7'h7D, 50, 6, 1, 0, 0, 50, 1};
    reset = 1'b1;
    seg_in = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_outputs", {digit, digit_valid, step, seq_error, pattern_error, period_valid}, 0);
    chk("reset_period", period, 0);
    for (int v = 0; v < 17; v++) begin
      nsteps = 0;
      st_seq = 0;
      st_pat = 0;
      hold(vecs[v].seg, vecs[v].n);
      chk($sformatf("v%0d_steps", v), nsteps, 1);
      chk($sformatf("v%0d_digit", v), digit, vecs[v].dg);
      chk($sformatf("v%0d_dvalid", v), digit_valid, vecs[v].dv);
      chk($sformatf("v%0d_seq", v), st_seq, vecs[v].sq);
      chk($sformatf("v%0d_pat", v), st_pat, vecs[v].pt);
      chk($sformatf("v%0d_period", v), period, vecs[v].per);
      chk($sformatf("v%0d_pvalid", v), period_valid, vecs[v].pv);
    end
    hold(7'h06, 20);
    nsteps = 0;
    hold(7'h7F, 3);
    hold(7'h06, 20);
    chk("glitch3_steps", nsteps, 0);
    chk("glitch3_digit", digit, 1);
    hold(7'h7F, 4);
    hold(7'h06, 20);
    chk("glitch4_steps", nsteps, 2);
    chk("glitch4_digit", digit, 1);
    hold(7'h5B, 2);
    reset = 1'b1;
    seg_in = 7'h00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midreset_outputs", {digit, digit_valid, step, seq_error, pattern_error, period_valid}, 0);
    chk("midreset_period", period, 0);
    nsteps = 0;
    hold(7'h00, 20);
    chk("midreset_nostale", nsteps, 0);
    st_seq = 1;
    hold(7'h6D, 20);
    chk("idle_first_steps", nsteps, 1);
    chk("idle_first_seq", st_seq, 0);
    chk("idle_first_digit", digit, 5);
    chk("idle_first_pvalid", period_valid, 0);
    for (int r = 0; r < 400; r++) begin
      int k;
      logic [6:0] p;
      k = $urandom_range(0, 9);
      p = k < 6 ? lut[$urandom_range(0, 9)] : k == 6 ? 7'h00 : 7'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
      hold(p, $urandom_range(0, 7) == 0 ? $urandom_range(200, 1200) : $urandom_range(1, 12));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
